// File: rtl/sti_deserializer.sv
// STI serial-to-parallel receiver.
// Rebuilds one contiguous si_valid run into a right-aligned 32-bit word and extracts the
// 16-bit payload. Frame length, bit order and fill mode are latched on the first bit of
// each frame. Length and padding problems are flagged alongside the result.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   si_data, si_valid   serial bit and its qualifier (one high run = one frame)
//   cfg_length          expected length: 00=8, 01=16, 10=24, 11=32 bits
//   cfg_msb             1 = MSB first, 0 = LSB first
//   cfg_fill            24/32-bit frames: 1 = payload in upper 16 bits, 0 = lower 16 bits
//   po_valid            one-cycle result pulse
//   po_word, po_data    raw received word and extracted payload (held until next frame)
//   po_len_err          bit count differs from expected, or more than 32 bits received
//   po_pad_err          padding bits not all zero
//   po_frames           completed frame count, wraps
module sti_deserializer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             si_data,
  input  logic             si_valid,
  input  logic [1:0]       cfg_length,
  input  logic             cfg_msb,
  input  logic             cfg_fill,
  output logic             po_valid,
  output logic [31:0]      po_word,
  output logic [15:0]      po_data,
  output logic             po_len_err,
  output logic             po_pad_err,
  output logic [CNT_W-1:0] po_frames
);

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  state_e           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [31:0]      w_q, w_d;
  logic [1:0]       len_q, len_d;
  logic             msb_q, msb_d;
  logic             fill_q, fill_d;

  logic             valid_q, valid_d;
  logic [31:0]      word_q, word_d;
  logic [15:0]      data_q, data_d;
  logic             len_err_q, len_err_d;
  logic             pad_err_q, pad_err_d;
  logic [CNT_W-1:0] frames_q, frames_d;

  logic [5:0]       n_bits;
  logic [15:0]      pay_data;
  logic             pay_pad;

  assign n_bits = {1'b0, len_q, 3'b000} + 6'd8;

  // Payload extraction always follows the latched length, even when the count is wrong.
  always_comb begin
    pay_data = w_q[15:0];
    pay_pad  = 1'b0;
    unique case (len_q)
      2'b00: pay_data = {8'h00, w_q[7:0]};
      2'b01: pay_data = w_q[15:0];
      2'b10: begin
        if (fill_q) begin
          pay_data = w_q[23:8];
          pay_pad  = |w_q[7:0];
        end else begin
          pay_data = w_q[15:0];
          pay_pad  = |w_q[23:16];
        end
      end
      2'b11: begin
        if (fill_q) begin
          pay_data = w_q[31:16];
          pay_pad  = |w_q[15:0];
        end else begin
          pay_data = w_q[15:0];
          pay_pad  = |w_q[31:16];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_d       = w_q;
    len_d     = len_q;
    msb_d     = msb_q;
    fill_d    = fill_q;
    valid_d   = 1'b0;
    word_d    = word_q;
    data_d    = data_q;
    len_err_d = len_err_q;
    pad_err_d = pad_err_q;
    frames_d  = frames_q;

    unique case (state_q)
      StIdle: begin
        if (si_valid) begin
          len_d   = cfg_length;
          msb_d   = cfg_msb;
          fill_d  = cfg_fill;
          // First bit lands in w[0] for either bit order.
          w_d     = {31'd0, si_data};
          cnt_d   = 6'd1;
          state_d = StRecv;
        end
      end
      StRecv: begin
        if (si_valid) begin
          if (cnt_q < 6'd32) begin
            if (msb_q) w_d = {w_q[30:0], si_data};
            else       w_d[cnt_q[4:0]] = si_data;
            cnt_d = cnt_q + 6'd1;
          end else begin
            // Overflow: drop the bit, freeze w, park the count at 33.
            cnt_d = 6'd33;
          end
        end else begin
          valid_d   = 1'b1;
          word_d    = w_q;
          data_d    = pay_data;
          len_err_d = (cnt_q != n_bits);
          pad_err_d = pay_pad;
          frames_d  = frames_q + {{(CNT_W-1){1'b0}}, 1'b1};
          cnt_d     = 6'd0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= 6'd0;
      w_q       <= 32'd0;
      len_q     <= 2'd0;
      msb_q     <= 1'b0;
      fill_q    <= 1'b0;
      valid_q   <= 1'b0;
      word_q    <= 32'd0;
      data_q    <= 16'd0;
      len_err_q <= 1'b0;
      pad_err_q <= 1'b0;
      frames_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_q       <= w_d;
      len_q     <= len_d;
      msb_q     <= msb_d;
      fill_q    <= fill_d;
      valid_q   <= valid_d;
      word_q    <= word_d;
      data_q    <= data_d;
      len_err_q <= len_err_d;
      pad_err_q <= pad_err_d;
      frames_q  <= frames_d;
    end
  end

  assign po_valid   = valid_q;
  assign po_word    = word_q;
  assign po_data    = data_q;
  assign po_len_err = len_err_q;
  assign po_pad_err = pad_err_q;
  assign po_frames  = frames_q;

endmodule

// File: tb/tb_sti_deserializer.sv
// Self-checking bench for sti_deserializer: directed frames plus randomized frames
// compared against a bit-list reference model.
module tb_sti_deserializer;
  localparam int unsigned CNT_W = 8;
  localparam int RW = 51 + CNT_W;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             si_data = 1'b0;
  logic             si_valid = 1'b0;
  logic [1:0]       cfg_length = 2'b00;
  logic             cfg_msb = 1'b0;
  logic             cfg_fill = 1'b0;
  logic             po_valid;
  logic [31:0]      po_word;
  logic [15:0]      po_data;
  logic             po_len_err;
  logic             po_pad_err;
  logic [CNT_W-1:0] po_frames;
  logic [RW-1:0]    obs;

  int tests_run = 0;
  int fails = 0;
  logic [CNT_W-1:0] exp_frames = '0;

  sti_deserializer #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .si_data   (si_data),
    .si_valid  (si_valid),
    .cfg_length(cfg_length),
    .cfg_msb   (cfg_msb),
    .cfg_fill  (cfg_fill),
    .po_valid  (po_valid),
    .po_word   (po_word),
    .po_data   (po_data),
    .po_len_err(po_len_err),
    .po_pad_err(po_pad_err),
    .po_frames (po_frames)
  );

  always #5 clk = ~clk;

  assign obs = {po_valid, po_word, po_data, po_len_err, po_pad_err, po_frames};

  // Reference: bit i of 'bits' is the i-th bit on the wire.
  function automatic logic [RW-1:0] expect_frame(input int n, input logic [63:0] bits,
                                                 input logic [1:0] len, input logic msb,
                                                 input logic fill,
                                                 input logic [CNT_W-1:0] frames);
    logic [63:0] w, wm, d;
    logic        pad;
    int          nn, k;
    nn = 8 * (int'(len) + 1);
    k  = (n > 32) ? 32 : n;
    w  = 64'd0;
    for (int i = 0; i < k; i++) begin
      if (msb) w = (w << 1) | {63'd0, bits[i]};
      else     w = w | ({63'd0, bits[i]} << i);
    end
    wm = w & ((64'd1 << nn) - 64'd1);
    if (nn <= 16) begin
      d   = wm;
      pad = 1'b0;
    end else if (fill) begin
      d   = wm >> (nn - 16);
      pad = (wm & ((64'd1 << (nn - 16)) - 64'd1)) != 64'd0;
    end else begin
      d   = wm;
      pad = (wm >> 16) != 64'd0;
    end
    return {1'b1, w[31:0], d[15:0], (n != nn), pad, frames};
  endfunction

  function automatic logic [63:0] msb_bits(input logic [63:0] val, input int n);
    logic [63:0] b = 64'd0;
    for (int i = 0; i < n; i++) b[i] = val[n-1-i];
    return b;
  endfunction

  // Starts and ends on a falling edge; drops si_valid after the last bit. Config is
  // scrambled after the first bit to show it is latched at frame start.
  task automatic drive_bits(input int n, input logic [63:0] bits, input logic [1:0] len,
                            input logic msb, input logic fill);
    for (int i = 0; i < n; i++) begin
      si_valid = 1'b1;
      si_data  = bits[i];
      if (i == 0) {cfg_length, cfg_msb, cfg_fill} = {len, msb, fill};
      else        {cfg_length, cfg_msb, cfg_fill} = 4'($urandom);
      @(negedge clk);
    end
    si_valid = 1'b0;
    si_data  = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [63:0] bits, input logic [1:0] len,
                            input logic msb, input logic fill);
    drive_bits(n, bits, len, msb, fill);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL reset_held got %h want 0", obs);
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL reset_release got %h want 0", obs);
    end
  endtask

  task automatic test_msb16();
    logic [RW-1:0] e;
    logic [63:0]   b = msb_bits(64'hA55A, 16);
    exp_frames++;
    e = expect_frame(16, b, 2'b01, 1'b1, 1'b0, exp_frames);
    send_frame(16, b, 2'b01, 1'b1, 1'b0);
    tests_run++;
    if (obs !== e) begin
      fails++;
      $display("FAIL msb16_frame got %h want %h", obs, e);
    end
    tests_run++;
    if ({po_valid, po_data, po_word, po_len_err, po_pad_err, po_frames} !==
        {1'b1, 16'hA55A, 32'h0000A55A, 1'b0, 1'b0, 8'd1}) begin
      fails++;
      $display("FAIL msb16_fields got data=%h word=%h le=%b pe=%b fr=%0d want A55A",
               po_data, po_word, po_len_err, po_pad_err, po_frames);
    end
    @(negedge clk);
    tests_run++;
    if ({po_valid, po_word} !== {1'b0, 32'h0000A55A}) begin
      fails++;
      $display("FAIL msb16_hold got v=%b word=%h want v=0 word=0000a55a", po_valid, po_word);
    end
  endtask

  task automatic test_lsb8();
    logic [RW-1:0] e;
    exp_frames++;
    e = expect_frame(8, 64'h3C, 2'b00, 1'b0, 1'b0, exp_frames);
    send_frame(8, 64'h3C, 2'b00, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e || po_data !== 16'h003C || po_len_err !== 1'b0) begin
      fails++;
      $display("FAIL lsb8 got %h want %h", obs, e);
    end
  endtask

  task automatic test_fill32();
    exp_frames++;
    send_frame(32, msb_bits(64'h12340000, 32), 2'b11, 1'b1, 1'b1);
    tests_run++;
    if ({po_valid, po_data, po_pad_err, po_len_err} !== {1'b1, 16'h1234, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL fill32_clean got data=%h pe=%b le=%b want 1234 0 0",
               po_data, po_pad_err, po_len_err);
    end
    exp_frames++;
    send_frame(32, msb_bits(64'h12340001, 32), 2'b11, 1'b1, 1'b1);
    tests_run++;
    if ({po_valid, po_data, po_pad_err} !== {1'b1, 16'h1234, 1'b1}) begin
      fails++;
      $display("FAIL fill32_pad got data=%h pe=%b want 1234 1", po_data, po_pad_err);
    end
  endtask

  task automatic test_len_err();
    logic [RW-1:0] e;
    logic [63:0]   b = {$urandom, $urandom};
    logic [31:0]   v = $urandom;
    logic [7:0]    x = 8'($urandom);
    exp_frames++;
    e = expect_frame(9, b, 2'b00, 1'b0, 1'b0, exp_frames);
    send_frame(9, b, 2'b00, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e || po_len_err !== 1'b1) begin
      fails++;
      $display("FAIL len_short got %h want %h", obs, e);
    end
    exp_frames++;
    send_frame(40, msb_bits({24'd0, v, x}, 40), 2'b11, 1'b1, 1'b0);
    tests_run++;
    if ({po_valid, po_len_err, po_word} !== {1'b1, 1'b1, v}) begin
      fails++;
      $display("FAIL len_overflow got le=%b word=%h want 1 %h", po_len_err, po_word, v);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0]      a = 16'($urandom);
    logic [15:0]      c = 16'($urandom);
    logic [CNT_W-1:0] f0 = po_frames;
    send_frame(16, msb_bits({48'd0, a}, 16), 2'b01, 1'b1, 1'b0);
    exp_frames++;
    tests_run++;
    if ({po_valid, po_word, po_len_err} !== {1'b1, 16'd0, a, 1'b0}) begin
      fails++;
      $display("FAIL b2b_first got v=%b word=%h want %h", po_valid, po_word, a);
    end
    // Second frame starts on the same falling edge the first result is sampled.
    send_frame(16, {48'd0, c}, 2'b01, 1'b0, 1'b0);
    exp_frames++;
    tests_run++;
    if ({po_valid, po_word, po_len_err, po_frames} !==
        {1'b1, 16'd0, c, 1'b0, f0 + CNT_W'(2)}) begin
      fails++;
      $display("FAIL b2b_second got v=%b word=%h fr=%0d want %h fr=%0d",
               po_valid, po_word, po_frames, c, f0 + CNT_W'(2));
    end
  endtask

  task automatic test_reset_midframe();
    logic [RW-1:0] e;
    logic [63:0]   b = {$urandom, $urandom};
    drive_bits(10, b, 2'b01, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    tests_run++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL midframe_reset got %h want 0", obs);
    end
    @(negedge clk);
    reset = 1'b1;
    exp_frames = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (po_valid !== 1'b0) begin
        fails++;
        $display("FAIL midframe_no_pulse got %b want 0", po_valid);
      end
    end
    exp_frames++;
    e = expect_frame(16, b, 2'b01, 1'b0, 1'b0, exp_frames);
    send_frame(16, b, 2'b01, 1'b0, 1'b0);
    tests_run++;
    if (obs !== e || po_frames !== 8'd1) begin
      fails++;
      $display("FAIL midframe_recover got %h want %h", obs, e);
    end
  endtask

  task automatic test_random();
    logic [RW-1:0] e;
    logic [63:0]   b;
    logic [1:0]    len;
    logic          msb, fill;
    int            n, gap;
    for (int k = 0; k < 60; k++) begin
      len  = 2'($urandom);
      msb  = 1'($urandom);
      fill = 1'($urandom);
      b    = {$urandom, $urandom};
      n    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 8 * (int'(len) + 1);
      gap  = $urandom_range(0, 2);
      exp_frames++;
      e = expect_frame(n, b, len, msb, fill, exp_frames);
      send_frame(n, b, len, msb, fill);
      tests_run++;
      if (obs !== e) begin
        fails++;
        $display("FAIL random_frame%0d n=%0d got %h want %h", k, n, obs, e);
      end
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        tests_run++;
        if ({po_valid, po_word} !== {1'b0, e[RW-2 -: 32]}) begin
          fails++;
          $display("FAIL random_gap%0d got v=%b word=%h want v=0 word=%h",
                   k, po_valid, po_word, e[RW-2 -: 32]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb16();
    test_lsb8();
    test_fill32();
    test_len_err();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
